// File: rtl/test_pattern_frame_sequencer_if.sv
// Control/status bundle between a run controller and test_pattern_frame_sequencer.
interface test_pattern_frame_sequencer_if;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [15:0] frame_count;
    logic        serial_out;
    logic        busy;
    logic        frame_start;
    logic        done;
    logic [15:0] frames_sent;

    modport master (
        output start, stop, mode, frame_count,
        input  serial_out, busy, frame_start, done, frames_sent
    );

    modport slave (
        input  start, stop, mode, frame_count,
        output serial_out, busy, frame_start, done, frames_sent
    );
endinterface

// File: rtl/test_pattern_frame_sequencer.sv
// Frame sequencer: preamble, sync word, pattern payload, idle gap on serial_out.
// Optional macro TPFS_CRC8_EN inserts a CRC-8 (poly 0x07) byte after the payload.
module test_pattern_frame_sequencer #(
    parameter int              BIT_DIV       = 1,
    parameter int              PREAMBLE_BITS = 16,
    parameter int              SYNC_W        = 16,
    parameter logic [SYNC_W-1:0] SYNC_WORD   = 16'hB5E3,
    parameter int              PAYLOAD_BITS  = 64,
    parameter int              GAP_BITS      = 8
) (
    input  logic clk,
    input  logic reset,
    test_pattern_frame_sequencer_if.slave bus
);
    localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [15:0] PRE_LAST  = 16'(PREAMBLE_BITS - 1);
    localparam logic [15:0] SYNC_LAST = 16'(SYNC_W - 1);
    localparam logic [15:0] PAY_LAST  = 16'(PAYLOAD_BITS - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SYNC,
        S_PAY,
`ifdef TPFS_CRC8_EN
        S_CRC,
`endif
        S_GAP
    } state_t;

    state_t           state, nstate;
    logic [DIV_W-1:0] div;
    logic [15:0]      idx, nidx;
    logic [1:0]       mode_q;
    logic [15:0]      count_q;
    logic [15:0]      sent_q;
    logic             stop_pend;
    logic [6:0]       prbs;
    logic             serial_q, busy_q, fs_q, done_q;
    logic             adv, last_run, nbit, pay_bit;
    logic [SYNC_W-1:0] sync_sh;
    logic [7:0]       cnt_byte, cnt_sh;

`ifdef TPFS_CRC8_EN
    logic [7:0] crc, crc_sh;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            div       <= '0;
            idx       <= '0;
            mode_q    <= '0;
            count_q   <= '0;
            sent_q    <= '0;
            stop_pend <= 1'b0;
            prbs      <= 7'h7F;
            serial_q  <= 1'b0;
            busy_q    <= 1'b0;
            fs_q      <= 1'b0;
            done_q    <= 1'b0;
`ifdef TPFS_CRC8_EN
            crc       <= '0;
`endif
        end else begin
            state  <= nstate;
            idx    <= nidx;
            busy_q <= (nstate != S_IDLE);
            fs_q   <= adv && nstate == S_PRE && nidx == 16'd0;
            done_q <= adv && state == S_GAP && nstate == S_IDLE;
            if (adv || state == S_IDLE) div <= '0;
            else                        div <= div + 1'b1;
            if (adv) serial_q <= nbit;
            // a stop that arrives together with start still counts
            if (state == S_IDLE) begin
                stop_pend <= bus.start & bus.stop;
                if (bus.start) begin
                    mode_q  <= bus.mode;
                    count_q <= bus.frame_count;
                    sent_q  <= '0;
                end
            end else if (nstate == S_IDLE) begin
                stop_pend <= 1'b0;
            end else if (bus.stop) begin
                stop_pend <= 1'b1;
            end
            if (adv && nstate == S_PRE && nidx == 16'd0) begin
                prbs <= 7'h7F;
`ifdef TPFS_CRC8_EN
                crc  <= '0;
`endif
            end
            if (adv && nstate == S_PAY) begin
                prbs <= {prbs[5:0], prbs[6] ^ prbs[5]};
`ifdef TPFS_CRC8_EN
                crc  <= crc8_step(crc, pay_bit);
`endif
            end
            if (adv && nstate == S_GAP && state != S_GAP && sent_q != 16'hFFFF)
                sent_q <= sent_q + 16'd1;
        end
    end

    always_comb begin
        adv      = (state == S_IDLE) ? bus.start : (div == DIV_LAST);
        last_run = (count_q != 16'd0 && sent_q == count_q) || stop_pend;
        nstate   = state;
        nidx     = idx;
        if (adv) begin
            nidx = idx + 16'd1;
            unique case (state)
                S_IDLE: begin
                    nstate = S_PRE;
                    nidx   = '0;
                end
                S_PRE: if (idx == PRE_LAST) begin
                    nstate = S_SYNC;
                    nidx   = '0;
                end
                S_SYNC: if (idx == SYNC_LAST) begin
                    nstate = S_PAY;
                    nidx   = '0;
                end
`ifdef TPFS_CRC8_EN
                S_PAY: if (idx == PAY_LAST) begin
                    nstate = S_CRC;
                    nidx   = '0;
                end
                S_CRC: if (idx == 16'd7) begin
                    nstate = S_GAP;
                    nidx   = '0;
                end
`else
                S_PAY: if (idx == PAY_LAST) begin
                    nstate = S_GAP;
                    nidx   = '0;
                end
`endif
                S_GAP: if (idx == GAP_LAST) begin
                    nstate = last_run ? S_IDLE : S_PRE;
                    nidx   = '0;
                end
                default: nstate = S_IDLE;
            endcase
        end
    end

    // nbit is the bit that goes on the line when the divider next wraps
    always_comb begin
        sync_sh  = SYNC_WORD << nidx;
        cnt_byte = nidx[10:3];
        cnt_sh   = cnt_byte << nidx[2:0];
`ifdef TPFS_CRC8_EN
        crc_sh   = crc << nidx[2:0];
`endif
        unique case (mode_q)
            2'b00:   pay_bit = prbs[6];
            2'b01:   pay_bit = cnt_sh[7];
            2'b10:   pay_bit = 1'b1;
            default: pay_bit = ~nidx[0];
        endcase
        unique case (nstate)
            S_PRE:   nbit = ~nidx[0];
            S_SYNC:  nbit = sync_sh[SYNC_W-1];
            S_PAY:   nbit = pay_bit;
`ifdef TPFS_CRC8_EN
            S_CRC:   nbit = crc_sh[7];
`endif
            default: nbit = 1'b0;
        endcase
    end

    assign bus.serial_out  = serial_q;
    assign bus.busy        = busy_q;
    assign bus.frame_start = fs_q;
    assign bus.done        = done_q;
    assign bus.frames_sent = sent_q;
endmodule
